alu_seq: RTL

Parametrised, handshaked sequential ALU, the next generation of the team's 16-bit combinational ALU. It keeps the AND/OR/ADD/SUB opcode encodings and adds XOR, logical shifts and a multi-cycle shift-add multiply. It produces status flags and registers its result behind a valid/ready interface, so it can sit between an instruction-issue stage and a writeback stage. One operation is in flight at a time, and the block supports back-to-back issue on single-cycle ops.

---
 rtl/alu_seq_pkg.sv | 28 ++
 rtl/alu_seq_if.sv | 32 +++
 rtl/alu_seq_mul.sv | 54 +++++
 rtl/alu_seq.sv | 139 +++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for alu_seq: opcode and FSM enums plus the status-flag bundle.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_XOR = 3'b011,
    OP_SHL = 3'b100,
    OP_SHR = 3'b101,
    OP_SUB = 3'b110,
    OP_MUL = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/alu_seq_if.sv
// Issue/writeback bundle for alu_seq: valid/ready request with operands, valid/ready response with flags.
interface alu_seq_if #(parameter int unsigned WIDTH = 16);
  import alu_seq_pkg::*;

  logic             in_valid;
  logic             in_ready;
  op_t              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;
  logic             illegal;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, result_hi,
           flag_z, flag_n, flag_c, flag_v, illegal
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, result_hi,
           flag_z, flag_n, flag_c, flag_v, illegal
  );

endinterface

// File: rtl/alu_seq_mul.sv
// Unsigned shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
module alu_seq_mul #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int unsigned CW = $clog2(WIDTH);

  logic               running;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH:0]     upper;

  // The add carry lands in the top bit and is shifted back into the accumulator.
  always_comb begin
    upper = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (mplier[0]) upper = upper + {1'b0, mcand};
    acc_nxt = {upper, acc[WIDTH-1:1]};
  end

  assign done    = running && (cnt == CW'(WIDTH - 1));
  assign product = acc_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      mcand   <= a;
      mplier  <= b;
      acc     <= '0;
    end else if (running) begin
      acc    <= acc_nxt;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU with flags. Define ALU_SEQ_MUL_EN to build the multi-cycle MUL;
// otherwise op 111 completes in one cycle flagged illegal.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  alu_seq_if.slave    bus
);
  localparam int unsigned SHW = $clog2(WIDTH);

  state_t             state;
  state_t             state_nxt;
  logic               accept;
  logic               mul_op;
  logic               mul_done;
  logic [2*WIDTH-1:0] product;

  logic [WIDTH-1:0]   bx;
  logic [WIDTH:0]     sum;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   res_c;
  flags_t             flg_c;
  logic               ill_c;

  logic [WIDTH-1:0]   res_q;
  logic [WIDTH-1:0]   hi_q;
  flags_t             flg_q;
  logic               ill_q;

  assign accept = bus.in_valid && bus.in_ready;

`ifdef ALU_SEQ_MUL_EN
  assign mul_op = (bus.op == OP_MUL);
  assign ill_c  = 1'b0;

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && mul_op),
    .a       (bus.a),
    .b       (bus.b),
    .done    (mul_done),
    .product (product)
  );
`else
  assign mul_op   = 1'b0;
  assign ill_c    = (bus.op == OP_MUL);
  assign mul_done = 1'b0;
  assign product  = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept)                              state_nxt = mul_op ? BUSY : DONE;
        else if (state == DONE && bus.out_ready) state_nxt = IDLE;
      end
      BUSY:    if (mul_done) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE:    bus.in_ready = 1'b1;
      DONE: begin
        bus.in_ready  = bus.out_ready;
        bus.out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // SUB shares the adder as a + ~b + 1, so flag_c reads as "no borrow".
  always_comb begin
    bx    = (bus.op == OP_SUB) ? ~bus.b : bus.b;
    sum   = {1'b0, bus.a} + {1'b0, bx} + {{WIDTH{1'b0}}, (bus.op == OP_SUB)};
    shamt = bus.b[SHW-1:0];
    res_c = '0;
    flg_c = '0;
    case (bus.op)
      OP_AND: res_c = bus.a & bus.b;
      OP_OR:  res_c = bus.a | bus.b;
      OP_XOR: res_c = bus.a ^ bus.b;
      OP_SHL: res_c = bus.a << shamt;
      OP_SHR: res_c = bus.a >> shamt;
      OP_ADD, OP_SUB: begin
        res_c   = sum[WIDTH-1:0];
        flg_c.c = sum[WIDTH];
        flg_c.v = (bus.a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_MUL: res_c = '0;
    endcase
    flg_c.z = (res_c == '0);
    flg_c.n = res_c[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
      hi_q  <= '0;
      flg_q <= '0;
      ill_q <= 1'b0;
    end else if (accept && !mul_op) begin
      res_q <= res_c;
      hi_q  <= '0;
      flg_q <= flg_c;
      ill_q <= ill_c;
    end else if (mul_done) begin
      res_q   <= product[WIDTH-1:0];
      hi_q    <= product[2*WIDTH-1:WIDTH];
      flg_q.z <= (product[WIDTH-1:0] == '0);
      flg_q.n <= product[WIDTH-1];
      flg_q.c <= |product[2*WIDTH-1:WIDTH];
      flg_q.v <= 1'b0;
      ill_q   <= 1'b0;
    end
  end

  assign bus.result    = res_q;
  assign bus.result_hi = hi_q;
  assign bus.flag_z    = flg_q.z;
  assign bus.flag_n    = flg_q.n;
  assign bus.flag_c    = flg_q.c;
  assign bus.flag_v    = flg_q.v;
  assign bus.illegal   = ill_q;

endmodule
